// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Owns the single register-file write port. The port is shared between the
// in-order writeback stage and the long-latency unit (mul/div, load-miss
// return). Long-latency results wait in a small FIFO and are written when
// writeback leaves the port idle. A starvation counter forces a drain slot by
// stalling writeback after STARVE_MAX consecutive writeback wins. The block
// also exports a mask of destinations still queued, for hazard detection.
//
// Parameters
//   DEPTH       long-latency result FIFO entries (>=1, power of two)
//   STARVE_MAX  writeback wins allowed while the FIFO is non-empty before a
//               forced drain (>=1)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data  writeback write request (zero-latency path)
//   wb_stall                writeback must hold; its write was not performed
//   lu_valid/lu_rd/lu_data  long-latency result offer
//   lu_ready                FIFO can accept (transfer on lu_valid && lu_ready)
//   rf_we/rf_rd/rf_data     register-file write port
//   pend_mask               bit i set while a queued entry targets x[i]
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,

  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,

  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,

  output logic [31:0] pend_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SC_W-1:0]    sc_q, sc_d;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  logic wb_req;
  logic fifo_ne;
  logic force_drain;
  logic fifo_gnt;
  logic wb_gnt;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  // Writes to x0 are architecturally void, so a wb request to x0 leaves the
  // port idle and a lu transfer to x0 completes its handshake without a push.
  // All grants are gated by rst_n so the port goes quiet the instant reset
  // asserts, even with wb_valid still high.
  assign wb_req      = wb_valid && (wb_rd != 5'd0);
  assign fifo_ne     = (count_q != '0);
  assign force_drain = fifo_ne && (sc_q == SC_W'(STARVE_MAX));
  assign fifo_gnt    = rst_n && (force_drain || (!wb_req && fifo_ne));
  assign wb_gnt      = rst_n && wb_req && !force_drain;
  assign wb_stall    = rst_n && wb_req && force_drain;

  // Ready depends only on registered count: a full FIFO stays closed even in
  // the cycle it pops, which keeps lu_ready off the grant path.
  assign lu_ready    = rst_n && (count_q < CNT_W'(DEPTH));
  assign push        = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop         = fifo_gnt;

  assign rf_we       = fifo_gnt || wb_gnt;
  assign rf_rd       = fifo_gnt ? mem_q[head_q].rd   : (wb_gnt ? wb_rd   : 5'd0);
  assign rf_data     = fifo_gnt ? mem_q[head_q].data : (wb_gnt ? wb_data : 32'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    sc_d    = sc_q;

    if (push) tail_d = next_ptr(tail_q);
    if (pop)  head_d = next_ptr(head_q);

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (!fifo_ne || fifo_gnt) begin
      sc_d = '0;
    end else if (wb_gnt && (sc_q != SC_W'(STARVE_MAX))) begin
      sc_d = sc_q + 1'b1;
    end
  end

  // Queued-destination mask, built from registered contents only, so an entry
  // is visible the cycle after its push and gone the cycle after its pop.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      int off;
      off = (i - int'(head_q) + DEPTH) % DEPTH;
      if (off < int'(count_q)) pend_mask[mem_q[i].rd] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      sc_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sc_q    <= sc_d;
    end
  end

  // NOTE: the storage array has no reset; validity comes solely from count_q
  // and the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{rd: lu_rd, data: lu_data};
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Directed bench for regfile_wr_arbiter with DEPTH=2, STARVE_MAX=4. Inputs
// change on the falling edge; outputs are sampled 1 ns later, well away from
// the rising edge that commits state.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] pend_mask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .pend_mask (pend_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic stall,
                           input logic ready, input logic [31:0] pend);
    check({tag, ".rf_we"},     32'(rf_we),     32'(we));
    check({tag, ".rf_rd"},     32'(rf_rd),     32'(rd));
    check({tag, ".rf_data"},   rf_data,        data);
    check({tag, ".wb_stall"},  32'(wb_stall),  32'(stall));
    check({tag, ".lu_ready"},  32'(lu_ready),  32'(ready));
    check({tag, ".pend_mask"}, pend_mask,      pend);
  endtask

  // Advance to the next falling edge, apply inputs, settle.
  task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    @(negedge clk);
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    lu_valid = lv; lu_rd = lr; lu_data = ld;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'h0;

    // Reset holds every output low, even with a live wb request.
    #2;
    check_out("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wb_valid = 1'b0;

    // --- Single long-latency result ---------------------------------------
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    check_out("lu_offer", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("lu_drain", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0000_0020);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("lu_idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);

    // --- Writeback priority over a queued entry ---------------------------
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h77);
    check_out("wb_push", 1'b1, 5'd3, 32'h11, 1'b0, 1'b1, 32'd0);
    step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    check_out("wb_over_fifo", 1'b1, 5'd3, 32'h33, 1'b0, 1'b1, 32'h0000_0080);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("fifo_on_idle", 1'b1, 5'd7, 32'h77, 1'b0, 1'b1, 32'h0000_0080);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("idle2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);

    // --- Starvation: 4 wb wins with an entry queued, then a forced slot ---
    step(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
    check_out("starve_push", 1'b1, 5'd1, 32'h100, 1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, 32'h101 + 32'(i), 1'b0, 5'd0, 32'd0);
      check_out($sformatf("starve_wb%0d", i), 1'b1, 5'd1, 32'h101 + 32'(i),
                1'b0, 1'b1, 32'h0000_0200);
    end
    step(1'b1, 5'd1, 32'h200, 1'b0, 5'd0, 32'd0);
    check_out("starve_force", 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 5'd1, 32'h200, 1'b0, 5'd0, 32'd0);
    check_out("starve_after", 1'b1, 5'd1, 32'h200, 1'b0, 1'b1, 32'd0);
    check("starve_sc", 32'(dut.sc_q), 32'd0);

    // --- Fill to full, pop while full, push+pop, FIFO order ---------------
    step(1'b1, 5'd2, 32'hA0, 1'b1, 5'd10, 32'h1010);
    check_out("fill0", 1'b1, 5'd2, 32'hA0, 1'b0, 1'b1, 32'd0);
    step(1'b1, 5'd2, 32'hA1, 1'b1, 5'd11, 32'h1111);
    check_out("fill1", 1'b1, 5'd2, 32'hA1, 1'b0, 1'b1, 32'h0000_0400);
    step(1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 32'd0);
    check_out("full", 1'b1, 5'd2, 32'hA2, 1'b0, 1'b0, 32'h0000_0C00);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212);
    check_out("full_pop", 1'b1, 5'd10, 32'h1010, 1'b0, 1'b0, 32'h0000_0C00);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212);
    check_out("push_pop", 1'b1, 5'd11, 32'h1111, 1'b0, 1'b1, 32'h0000_0800);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("drain_last", 1'b1, 5'd12, 32'h1212, 1'b0, 1'b1, 32'h0000_1000);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("drained", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);

    // --- x0 writes dropped; wb to x0 leaves the port to the FIFO ----------
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    check_out("x0_both", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("x0_not_pushed", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h6666);
    check_out("x0_setup", 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 32'd0);
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    check_out("x0_wb_idle", 1'b1, 5'd6, 32'h6666, 1'b0, 1'b1, 32'h0000_0040);

    // --- Reset mid-operation with 2 entries queued and sc=3 ---------------
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD);
    step(1'b1, 5'd1, 32'h2, 1'b1, 5'd14, 32'hE);
    step(1'b1, 5'd1, 32'h3, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd1, 32'h4, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd1, 32'h5, 1'b0, 5'd0, 32'd0);
    check("mid_sc", 32'(dut.sc_q), 32'd3);
    check_out("mid_pre", 1'b1, 5'd1, 32'h5, 1'b0, 1'b0, 32'h0000_6000);
    rst_n = 1'b0;
    #1;
    check_out("mid_in_reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    wb_valid = 1'b0; lu_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_count", 32'(dut.count_q), 32'd0);
    check_out("post_reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_out("post_idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Owns the single register-file write port and shares it between the in-order writeback stage and the long-latency unit (multiply/divide, load-miss return). Long-latency results are held in a small FIFO and written when the writeback stage leaves the port idle. A starvation counter forces a drain slot by stalling writeback. The block exports a pending-destination mask so hazard logic can hold dependents.

## Interface
- DEPTH, 2, long-latency result FIFO entries (≥1, power of two)
- STARVE_MAX, 4, consecutive writeback wins allowed while FIFO non-empty before a forced drain (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  writeback stage wants to write (its ld_regfile)
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback result (regfile mux output)
- wb_stall  out  1  writeback must hold its instruction this cycle (write not performed)
- lu_valid  in  1  long-latency result offered
- lu_rd  in  5  long-latency destination
- lu_data  in  32  long-latency result
- lu_ready  out  1  FIFO can accept; transfer on lu_valid && lu_ready
- rf_we  out  1  regfile write enable
- rf_rd  out  5  regfile write index
- rf_data  out  32  regfile write data
- pend_mask  out  32  bit i set when any FIFO entry targets x[i]; bit 0 always 0

## Operation
- State: FIFO (DEPTH × {rd, data}, head/tail pointers, count 0..DEPTH), starvation counter sc (0..STARVE_MAX).
- Writes with rd = 0 are dropped: wb_valid with wb_rd = 0 counts as port idle; lu transfers with lu_rd = 0 are accepted (handshake completes) but not pushed.
- Grant, evaluated combinationally each cycle:
  - force = (count > 0) && (sc == STARVE_MAX) -> FIFO head wins; wb_stall = wb_valid && wb_rd != 0.
  - else wb_valid && wb_rd != 0 -> writeback wins; wb_stall = 0.
  - else count > 0 -> FIFO head wins.
  - else rf_we = 0.
- rf_rd/rf_data = winner's fields; rf_rd = 0, rf_data = 0 when rf_we = 0.
- Pop on FIFO grant; push on accepted lu transfer with lu_rd != 0.
- lu_ready = (count < DEPTH), from registered count only; no pop-through when full.
- sc update: count == 0 -> 0; FIFO granted -> 0; writeback granted with count > 0 -> sc + 1 (saturates at STARVE_MAX); otherwise hold.
- pend_mask = OR over valid entries of one-hot(rd), from registered FIFO contents; a result becomes visible in pend_mask the cycle after push and clears the cycle after pop.
- Ordering: issue logic guarantees no writeback-stage write to a register set in pend_mask or in flight in the long-latency unit; the arbiter does not reorder same-rd writes.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, sc = 0; while low, rf_we = 0, wb_stall = 0, lu_ready = 0, pend_mask = 0. lu_ready = 1 from the first cycle after release.
- Writeback path: zero latency, same-cycle write when granted.
- Long-latency path: minimum one cycle from accepted transfer to rf_we (no bypass).
- Full FIFO plus simultaneous pop: lu_ready stays 0 that cycle; it rises the next cycle.
- Simultaneous push and pop on a non-full FIFO: count unchanged; the head entry written is the older entry.
- Worst-case FIFO entry wait with continuous writeback: STARVE_MAX cycles of writeback grants, then a forced slot. The maximum wb_stall duty is 1 in STARVE_MAX+1 while the FIFO stays non-empty.
- Reset mid-operation: FIFO contents are discarded; no partial write occurs.

## Test plan
- Reset, then lu_valid with rd=5, data=0xDEADBEEF, wb_valid=0 -> lu_ready=1; next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF; pend_mask bit5 set for exactly that one cycle.
- Same cycle wb_valid (rd=3, 0x11) and FIFO holding rd=7 -> writeback writes x3, wb_stall=0; FIFO drains x7 in the first cycle wb_valid=0.
- Continuous wb_valid rd=1 with one FIFO entry rd=9, STARVE_MAX=4 -> four cycles writing x1, fifth cycle rf_rd=9 with wb_stall=1, sixth cycle x1 again with sc=0.
- Fill FIFO with DEPTH=2 pushes while writeback is busy -> lu_ready=0 after the second push; it stays 0 on the pop cycle and returns to 1 the next cycle; data drains in FIFO order.
- wb_valid with rd=0, and lu push with rd=0 -> rf_we never asserts for x0; pend_mask bit0=0; the FIFO head is granted in the wb rd=0 cycle.
- Assert rst_n low with 2 entries queued and sc=3 -> outputs drop immediately; after release, count=0, rf_we=0, lu_ready=1.
